// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: register offsets, base address and the address decoder.
package gpio_pkg;

  // Base of the GPIO window, as seen by the CPU's address decoder.
  localparam logic [31:0] GPIO_BASE = 32'h8000_0000;

  // Register offsets inside the window (byte addresses).
  localparam logic [7:0] GPIO_LED      = 8'h00;
  localparam logic [7:0] GPIO_SW       = 8'h04;
  localparam logic [7:0] GPIO_CHANGED  = 8'h08;
  localparam logic [7:0] GPIO_IRQ_MASK = 8'h0C;

  typedef enum logic [2:0] {
    SEL_LED,
    SEL_SW,
    SEL_CHANGED,
    SEL_IRQ_MASK,
    SEL_NONE
  } gpio_sel_e;

  // Word-aligned offset (low two bits already zeroed) to register select.
  function automatic gpio_sel_e gpio_decode(input logic [31:0] offset);
    gpio_sel_e sel;
    sel = SEL_NONE;
    if (offset == 32'(GPIO_LED))      sel = SEL_LED;
    if (offset == 32'(GPIO_SW))       sel = SEL_SW;
    if (offset == 32'(GPIO_CHANGED))  sel = SEL_CHANGED;
    if (offset == 32'(GPIO_IRQ_MASK)) sel = SEL_IRQ_MASK;
    return sel;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Two-flop synchroniser plus whole-vector debouncer for the switch pins.
// update is non-zero only in the cycle whose closing edge changes sw_stable,
// and then carries old ^ new so the caller can set its sticky bits on that edge.
module gpio_debounce #(
  parameter int SW_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switches,
  output logic [SW_WIDTH-1:0] sw_stable,
  output logic [SW_WIDTH-1:0] update
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] sync1_q, sync1_d;
  logic [SW_WIDTH-1:0] sync2_q, sync2_d;
  logic [SW_WIDTH-1:0] cand_q, cand_d;
  logic [SW_WIDTH-1:0] sw_stable_q, sw_stable_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Next-state: restart on any candidate change, accept after a full stable run.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    sync1_d     = switches;
    sync2_d     = sync1_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    sw_stable_d = sw_stable_q;
    update      = '0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cand_q != sw_stable_q) begin
      if (cnt_q == CNT_LAST) begin
        sw_stable_d = cand_q;
        cnt_d       = '0;
        update      = cand_q ^ sw_stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers; reset discards any pending candidate.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      sw_stable_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      sw_stable_q <= sw_stable_d;
    end
  end

  assign sw_stable = sw_stable_q;

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO responder: LED register, debounced switches, sticky
// change flags with W1C, interrupt mask and a registered level interrupt.
module mmio_gpio
  import gpio_pkg::*;
#(
  parameter int SW_WIDTH        = 8,
  parameter int LED_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADDR_W          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [31:0]          req_wdata,
  output logic [31:0]          rdata,
  output logic                 rvalid,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 irq
);

  logic [SW_WIDTH-1:0]  sw_stable;
  logic [SW_WIDTH-1:0]  sw_update;
  logic [ADDR_W-1:0]    addr_word;
  gpio_sel_e            sel;
  logic                 rd_en, wr_en;

  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic [SW_WIDTH-1:0]  sw_changed_q, sw_changed_d;
  logic [SW_WIDTH-1:0]  irq_mask_q, irq_mask_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 irq_q, irq_d;

  gpio_debounce #(
    .SW_WIDTH       (SW_WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .switches (switches),
    .sw_stable(sw_stable),
    .update   (sw_update)
  );

  assign addr_word = {req_addr[ADDR_W-1:2], 2'b00};
  assign sel       = gpio_decode(32'(addr_word));
  assign rd_en     = req_valid && !req_we;
  assign wr_en     = req_valid &&  req_we;

  // Register writes, read mux and interrupt level, all from pre-edge state.
  always_comb begin
    leds_d       = leds_q;
    irq_mask_d   = irq_mask_q;
    sw_changed_d = sw_changed_q;
    rdata_d      = rdata_q;
    rvalid_d     = rd_en;
    irq_d        = |(sw_changed_q & irq_mask_q);

    if (wr_en) begin
      case (sel)
        SEL_LED:      leds_d       = req_wdata[LED_WIDTH-1:0];
        SEL_CHANGED:  sw_changed_d = sw_changed_q & ~req_wdata[SW_WIDTH-1:0];
        SEL_IRQ_MASK: irq_mask_d   = req_wdata[SW_WIDTH-1:0];
        default:      ;
      endcase
    end
    // A debounced change sets its bits after any clear, so a set wins.
    sw_changed_d = sw_changed_d | sw_update;

    if (rd_en) begin
      case (sel)
        SEL_LED:      rdata_d = 32'(leds_q);
        SEL_SW:       rdata_d = 32'(sw_stable);
        SEL_CHANGED:  rdata_d = 32'(sw_changed_q);
        SEL_IRQ_MASK: rdata_d = 32'(irq_mask_q);
        default:      rdata_d = '0;
      endcase
    end
  end

  // Register file and response flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_q       <= '0;
      sw_changed_q <= '0;
      irq_mask_q   <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      leds_q       <= leds_d;
      sw_changed_q <= sw_changed_d;
      irq_mask_q   <= irq_mask_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      irq_q        <= irq_d;
    end
  end

  assign leds   = leds_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio: reset, debounce latency, glitch rejection,
// register map, W1C/set collision, irq lag and reset mid-debounce.
module tb_mmio_gpio;
  import gpio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic [7:0]  switches;
  logic [7:0]  leds;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        valid;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_rvalid;
    logic [7:0]  exp_leds;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[16];

  mmio_gpio #(
    .SW_WIDTH       (8),
    .LED_WIDTH      (8),
    .DEBOUNCE_CYCLES(4),
    .ADDR_W         (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .switches (switches),
    .leds     (leds),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One active edge, then settle on the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus(input logic v, input logic we, input logic [7:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, a, d);
    tick();
    idle();
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    bus(1'b1, 1'b0, a, 32'h0);
    tick();
    check(name, rdata, exp);
    check({name, "_rvalid"}, 32'(rvalid), 32'h1);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // LED write/readback, unmapped access, mask/irq lag, W1C, back-to-back reads.
    vecs[0]  = '{1'b1, 1'b1, GPIO_LED,      32'h0000_005C, 32'hAA, 1'b0, 8'h5C, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, GPIO_LED,      32'h0,         32'h5C, 1'b1, 8'h5C, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00,         32'h0,         32'h5C, 1'b0, 8'h5C, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h10,         32'h0,         32'h00, 1'b1, 8'h5C, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'h10,         32'hFFFF_FFFF, 32'h00, 1'b0, 8'h5C, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, GPIO_IRQ_MASK, 32'h0000_0002, 32'h00, 1'b0, 8'h5C, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00,         32'h0,         32'h00, 1'b0, 8'h5C, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, GPIO_LED,      32'h0,         32'h5C, 1'b1, 8'h5C, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, GPIO_SW,       32'h0,         32'hAA, 1'b1, 8'h5C, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, GPIO_IRQ_MASK, 32'h0,         32'h02, 1'b1, 8'h5C, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00,         32'h0,         32'h02, 1'b0, 8'h5C, 1'b1};
    vecs[11] = '{1'b1, 1'b1, GPIO_CHANGED,  32'h0000_0002, 32'h02, 1'b0, 8'h5C, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 8'h00,         32'h0,         32'h02, 1'b0, 8'h5C, 1'b0};
    vecs[13] = '{1'b1, 1'b0, GPIO_CHANGED,  32'h0,         32'hA8, 1'b1, 8'h5C, 1'b0};
    vecs[14] = '{1'b1, 1'b1, GPIO_SW,       32'h0000_00FF, 32'hA8, 1'b0, 8'h5C, 1'b0};
    vecs[15] = '{1'b1, 1'b0, GPIO_SW,       32'h0,         32'hAA, 1'b1, 8'h5C, 1'b0};

    // Reset state with switches already at 0xAA.
    reset    = 1'b0;
    switches = 8'hAA;
    idle();
    repeat (3) @(negedge clk);
    check("rst_leds",   32'(leds),   32'h0);
    check("rst_irq",    32'(irq),    32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata",  rdata,       32'h0);

    // Release on a falling edge; the next rising edge is edge N.
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("post_rst_irq_%0d", i), 32'(irq), 32'h0);
      check($sformatf("post_rst_leds_%0d", i), 32'(leds), 32'h0);
    end

    // Switch capture: read accepted at N+6 sees 0, at N+7 sees 0xAA.
    bus(1'b1, 1'b0, GPIO_SW, 32'h0);
    tick();
    check("sw_at_n6", rdata, 32'h0);
    check("sw_at_n6_rvalid", 32'(rvalid), 32'h1);
    tick();
    check("sw_at_n7", rdata, 32'hAA);
    check("sw_at_n7_rvalid", 32'(rvalid), 32'h1);
    idle();
    tick();
    check("rvalid_drop", 32'(rvalid), 32'h0);
    check("rdata_hold", rdata, 32'hAA);
    read_chk("changed_initial", GPIO_CHANGED, 32'hAA);
    check("irq_masked_off", 32'(irq), 32'h0);

    // Glitch rejection: 0xAB for three cycles only.
    switches = 8'hAB;
    repeat (3) tick();
    switches = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("glitch_irq_%0d", i), 32'(irq), 32'h0);
    end
    read_chk("glitch_sw", GPIO_SW, 32'hAA);
    read_chk("glitch_changed", GPIO_CHANGED, 32'hAA);

    // Table-driven register accesses, one bus cycle per entry.
    for (int i = 0; i < 16; i++) begin
      bus(vecs[i].valid, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      tick();
      check($sformatf("vec%0d_rdata", i),  rdata,        vecs[i].exp_rdata);
      check($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].exp_rvalid));
      check($sformatf("vec%0d_leds", i),   32'(leds),   32'(vecs[i].exp_leds));
      check($sformatf("vec%0d_irq", i),    32'(irq),    32'(vecs[i].exp_irq));
    end
    idle();

    // W1C of all bits on the same edge that a new change sets bit0.
    switches = 8'hAB;
    repeat (6) tick();
    write_reg(GPIO_CHANGED, 32'h0000_00FF);
    read_chk("collide_changed", GPIO_CHANGED, 32'h01);
    read_chk("collide_sw", GPIO_SW, 32'hAB);
    check("collide_irq", 32'(irq), 32'h0);

    // irq follows a mask change one cycle late.
    write_reg(GPIO_IRQ_MASK, 32'h0000_0001);
    check("mask_irq_lag", 32'(irq), 32'h0);
    tick();
    check("mask_irq_set", 32'(irq), 32'h1);

    // Asynchronous reset in the middle of a debounce run.
    switches = 8'h3C;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_leds",   32'(leds),   32'h0);
    check("mid_rst_irq",    32'(irq),    32'h0);
    check("mid_rst_rdata",  rdata,       32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) tick();
    bus(1'b1, 1'b0, GPIO_SW, 32'h0);
    tick();
    check("reacq_sw_n6", rdata, 32'h0);
    tick();
    check("reacq_sw_n7", rdata, 32'h3C);
    idle();
    read_chk("reacq_changed", GPIO_CHANGED, 32'h3C);
    read_chk("reacq_mask", GPIO_IRQ_MASK, 32'h0);
    check("reacq_irq", 32'(irq), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
